// File: rtl/fix_slave_pkg.sv
// Shared definitions for the FIX slave register window and its fabric-side master.
package fix_slave_pkg;

    // Register map of the FIX slave window
    localparam logic [2:0] CONN_ADDR = 3'b110;
    localparam logic [2:0] STAT_ADDR = 3'b000;
    localparam logic [2:0] DATA_ADDR = 3'b001;

    // Writing this byte to CONN_ADDR starts a session; the slave clears status on it
    localparam logic [7:0] CONN_CMD = 8'hDD;

    // Status register bit that reads 1 once the slave has a message ready
    localparam int STATUS_SENT_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CONN    = 4'd1,
        ST_SETTLE  = 4'd2,
        ST_POLL_RD = 4'd3,
        ST_POLL_WT = 4'd4,
        ST_GAP     = 4'd5,
        ST_DATA_RD = 4'd6,
        ST_DATA_WT = 4'd7,
        ST_OUT     = 4'd8,
        ST_DONE    = 4'd9,
        ST_ERR     = 4'd10
    } master_state_t;

    // States in which the poll timeout is running
    function automatic logic is_poll_state(master_state_t s);
        return (s == ST_SETTLE) || (s == ST_POLL_RD) ||
               (s == ST_POLL_WT) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/fix_slave_master_if.sv
// Avalon-MM register bus plus the outgoing byte stream of the FIX slave master.
//
// Avalon side: master_read / master_write are single-cycle strobes, never both
// high; master_readdata is valid exactly one cycle after master_read; there is
// no waitrequest. Stream side: a byte transfers on a rising edge where
// out_valid & out_ready; once out_valid is high, out_data holds steady until
// that transfer, and out_valid never depends on out_ready.
interface fix_slave_master_if;
    logic [2:0] master_address;
    logic       master_read;
    logic       master_write;
    logic [7:0] master_writedata;
    logic [7:0] master_readdata;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output master_address, master_read, master_write, master_writedata,
        input  master_readdata,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        input  master_address, master_read, master_write, master_writedata,
        output master_readdata,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/fix_poll_timer.sv
// Poll timeout counter: cleared on load, counts ticks, flags the tick that hits LIMIT.
module fix_poll_timer #(
    parameter logic [15:0] LIMIT = 16'd4096
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic tick_i,
    output logic expire_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: load wins over tick
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The LIMIT-th tick since load is the expiring one
    assign expire_o = tick_i && !load_i && (cnt_q == LIMIT - 16'd1);

endmodule

// File: rtl/fix_slave_master.sv
// Fabric-side master for the FIX slave: connect, poll status, stream msg_len bytes out.
module fix_slave_master
    import fix_slave_pkg::*;
#(
    parameter int unsigned POLL_GAP     = 4,
    parameter logic [15:0] POLL_TIMEOUT = 16'd4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            msg_len,
    fix_slave_master_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output master_state_t         dbg_state_o
);

    master_state_t state_q;
    logic [2:0]    addr_q;
    logic          read_q;
    logic          write_q;
    logic [7:0]    wdata_q;
    logic          out_valid_q;
    logic [7:0]    out_data_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic [7:0]    len_q;
    logic [7:0]    byte_cnt_q;
    logic [7:0]    gap_cnt_q;

    logic accept;
    logic tmo_expire;

    assign accept = (state_q == ST_IDLE) && start;

    fix_poll_timer #(.LIMIT(POLL_TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (accept),
        .tick_i   (is_poll_state(state_q)),
        .expire_o (tmo_expire)
    );

    // Transaction sequencer; every bus and stream output is a register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
        end else begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q      <= msg_len;
                        byte_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        write_q    <= 1'b1;
                        addr_q     <= CONN_ADDR;
                        wdata_q    <= CONN_CMD;
                        state_q    <= ST_CONN;
                    end
                end
                ST_CONN: begin
                    // Two quiet cycles so a stale "sent" bit is not read back
                    gap_cnt_q <= 8'd1;
                    state_q   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (tmo_expire) begin
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end else if (gap_cnt_q == 8'd0) begin
                        read_q  <= 1'b1;
                        addr_q  <= STAT_ADDR;
                        state_q <= ST_POLL_RD;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                ST_POLL_RD: begin
                    if (tmo_expire) begin
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        state_q <= ST_POLL_WT;
                    end
                end
                ST_POLL_WT: begin
                    // A "sent" status wins over a timeout landing on the same cycle
                    if (bus.master_readdata[STATUS_SENT_BIT]) begin
                        if (len_q == 8'd0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            read_q  <= 1'b1;
                            addr_q  <= DATA_ADDR;
                            state_q <= ST_DATA_RD;
                        end
                    end else if (tmo_expire) begin
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        gap_cnt_q <= 8'(POLL_GAP - 1);
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmo_expire) begin
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end else if (gap_cnt_q == 8'd0) begin
                        read_q  <= 1'b1;
                        addr_q  <= STAT_ADDR;
                        state_q <= ST_POLL_RD;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                ST_DATA_RD: begin
                    state_q <= ST_DATA_WT;
                end
                ST_DATA_WT: begin
                    out_data_q  <= bus.master_readdata;
                    out_valid_q <= 1'b1;
                    byte_cnt_q  <= byte_cnt_q + 8'd1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    // Next read only after the consumer takes this byte
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (byte_cnt_q == len_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            read_q  <= 1'b1;
                            addr_q  <= DATA_ADDR;
                            state_q <= ST_DATA_RD;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.master_address   = addr_q;
    assign bus.master_read      = read_q;
    assign bus.master_write     = write_q;
    assign bus.master_writedata = wdata_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_data         = out_data_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign error                = error_q;
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_fix_slave_master.sv
// Directed bench for fix_slave_master with a behavioural FIX slave register model.
module tb_fix_slave_master;
    import fix_slave_pkg::*;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    msg_len = 8'd0;
    logic          busy;
    logic          done;
    logic          error;
    master_state_t dbg_state;
    int            cyc = 0;

    fix_slave_master_if bus();

    fix_slave_master #(.POLL_GAP(4), .POLL_TIMEOUT(16'd64)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .msg_len     (msg_len),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- slave register model ----------------
    int         sent_after = 1;   // index of the status read that first returns 1
    int         poll_n = 0;
    int         data_idx = 0;
    logic [7:0] data_mem [0:7];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.master_readdata <= 8'h00;
        end else begin
            if (bus.master_write && bus.master_address == CONN_ADDR &&
                bus.master_writedata == CONN_CMD) begin
                poll_n   = 0;
                data_idx = 0;
            end
            if (bus.master_read) begin
                if (bus.master_address == STAT_ADDR) begin
                    poll_n = poll_n + 1;
                    bus.master_readdata <= (poll_n >= sent_after) ? 8'h01 : 8'h00;
                end else begin
                    bus.master_readdata <= data_mem[data_idx[2:0]];
                    data_idx = data_idx + 1;
                end
            end
        end
    end

    // ---------------- scoreboard / checking ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         rd0, rd1, wr_cnt, ov_cnt, hs_cnt, done_cnt, err_cnt;
    int         done_cyc, err_cyc, first_ov_cyc, wr_cyc, stall_cyc, viol;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       done_busy, err_busy, hold_q;
    logic [7:0] hold_data;
    int         rd0_cyc [$];

    task automatic clear_mon();
        rd0 = 0; rd1 = 0; wr_cnt = 0; ov_cnt = 0; hs_cnt = 0;
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
        first_ov_cyc = -1; wr_cyc = -1; stall_cyc = 0; viol = 0;
        wr_addr = '0; wr_data = '0; done_busy = 1'b1; err_busy = 1'b1;
        hold_q = 1'b0; hold_data = '0;
        rd0_cyc.delete();
        exp_q.delete();
    endtask

    // Bus/stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            if (bus.master_read && bus.master_write) viol++;
            if (bus.master_read && bus.master_address == STAT_ADDR) begin
                rd0++;
                rd0_cyc.push_back(cyc);
            end
            if (bus.master_read && bus.master_address == DATA_ADDR) begin
                rd1++;
                if (bus.out_valid) viol++;
            end
            if (bus.master_write) begin
                wr_cnt++;
                wr_addr = bus.master_address;
                wr_data = bus.master_writedata;
                wr_cyc  = cyc;
            end
            if (bus.out_valid) begin
                ov_cnt++;
                if (first_ov_cyc < 0) first_ov_cyc = cyc;
                if (hold_q && bus.out_data !== hold_data) viol++;
            end
            if (bus.out_valid && !bus.out_ready) begin
                stall_cyc++;
                hold_q    = 1'b1;
                hold_data = bus.out_data;
            end else begin
                hold_q = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 32'd1);
                else chk("byte", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (error) begin
                err_cnt++;
                err_cyc  = cyc;
                err_busy = busy;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_start(input logic [7:0] len, output int k0);
        start   = 1'b1;
        msg_len = len;
        k0      = cyc;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_end(input int max);
        for (int i = 0; i < max; i++) begin
            if (done_cnt > 0 || err_cnt > 0) break;
            step();
        end
        if (done_cnt == 0 && err_cnt == 0) chk("end_timeout", 32'd0, 32'd1);
        step(2);
    endtask

    function automatic logic [31:0] outs_word();
        return {3'd0, bus.master_address, bus.master_read, bus.master_write,
                bus.master_writedata, bus.out_valid, bus.out_data,
                busy, done, error, dbg_state};
    endfunction

    // ---------------- directed tests ----------------
    initial begin
        int  k0;
        logic found;
        bus.out_ready = 1'b1;
        clear_mon();
        step(2);
        chk("reset_outs", outs_word(), 32'd0);
        reset = 1'b1;
        step(2);

        // T1: status already set, three bytes, consumer always ready
        sent_after = 1;
        data_mem[0] = 8'h38; data_mem[1] = 8'h3D; data_mem[2] = 8'h46;
        clear_mon();
        exp_q.push_back(8'h38); exp_q.push_back(8'h3D); exp_q.push_back(8'h46);
        run_start(8'd3, k0);
        wait_end(200);
        chk("t1_wr_cnt", wr_cnt, 1);
        chk("t1_wr_addr", {29'd0, wr_addr}, 32'd6);
        chk("t1_wr_data", {24'd0, wr_data}, 32'hDD);
        chk("t1_wr_cyc", wr_cyc, k0 + 1);
        chk("t1_first_valid", first_ov_cyc, k0 + 8);
        chk("t1_done_cyc", done_cyc, k0 + 15);
        chk("t1_rd_stat", rd0, 1);
        chk("t1_rd_data", rd1, 3);
        chk("t1_bytes", hs_cnt, 3);
        chk("t1_done_busy", {31'd0, done_busy}, 32'd0);
        chk("t1_err", err_cnt, 0);
        chk("t1_viol", viol, 0);
        chk("t1_left", 32'(exp_q.size()), 32'd0);

        // T2: status goes 1 on the fifth poll
        sent_after = 5;
        data_mem[0] = 8'h11; data_mem[1] = 8'h22;
        clear_mon();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        run_start(8'd2, k0);
        wait_end(300);
        chk("t2_rd_stat", rd0, 5);
        if (rd0_cyc.size() > 0) chk("t2_first_poll", rd0_cyc[0], k0 + 4);
        for (int i = 1; i < rd0_cyc.size(); i++) begin
            chk("t2_poll_spacing", rd0_cyc[i] - rd0_cyc[i-1], 6);
        end
        chk("t2_first_valid", first_ov_cyc, k0 + 32);
        chk("t2_bytes", hs_cnt, 2);
        chk("t2_done", done_cnt, 1);
        chk("t2_viol", viol, 0);

        // T3: status never set, timeout of 64
        sent_after = 1000;
        clear_mon();
        run_start(8'd4, k0);
        wait_end(300);
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_err_cyc", err_cyc, k0 + 66);
        chk("t3_err_busy", {31'd0, err_busy}, 32'd0);
        chk("t3_rd_data", rd1, 0);
        chk("t3_rd_stat", rd0, 11);
        chk("t3_done", done_cnt, 0);
        chk("t3_valid", ov_cnt, 0);
        chk("t3_busy_after", {31'd0, busy}, 32'd0);

        // T4: msg_len 0, plus a start raised during the DONE cycle
        sent_after = 1;
        clear_mon();
        run_start(8'd0, k0);
        step(5);
        start = 1'b1;
        step();
        start = 1'b0;
        step(12);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_done_cyc", done_cyc, k0 + 6);
        chk("t4_rd_data", rd1, 0);
        chk("t4_valid", ov_cnt, 0);
        chk("t4_start_in_done", wr_cnt, 1);
        chk("t4_idle_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});

        // T5: ten cycles of backpressure on byte 2
        sent_after = 1;
        data_mem[0] = 8'hA1; data_mem[1] = 8'hB2; data_mem[2] = 8'hC3;
        clear_mon();
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
        run_start(8'd3, k0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid && hs_cnt == 1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("t5_reach_byte2", {31'd0, found}, 32'd1);
        bus.out_ready = 1'b0;
        step(10);
        bus.out_ready = 1'b1;
        wait_end(200);
        chk("t5_stall_cycles", stall_cyc, 10);
        chk("t5_viol", viol, 0);
        chk("t5_rd_data", rd1, 3);
        chk("t5_bytes", hs_cnt, 3);
        chk("t5_done_cyc", done_cyc, k0 + 25);
        chk("t5_left", 32'(exp_q.size()), 32'd0);

        // T6: reset in the data phase, then a fresh transaction
        sent_after = 1;
        data_mem[0] = 8'h5A; data_mem[1] = 8'h6B; data_mem[2] = 8'h7C;
        clear_mon();
        exp_q.push_back(8'h5A); exp_q.push_back(8'h6B); exp_q.push_back(8'h7C);
        run_start(8'd3, k0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (hs_cnt == 1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("t6_reach_byte1", {31'd0, found}, 32'd1);
        reset = 1'b0;
        step();
        chk("t6_rst_outs_a", outs_word(), 32'd0);
        step(2);
        chk("t6_rst_outs_b", outs_word(), 32'd0);
        clear_mon();
        reset = 1'b1;
        step(2);
        exp_q.push_back(8'h5A); exp_q.push_back(8'h6B);
        run_start(8'd2, k0);
        wait_end(200);
        chk("t6_wr_cnt", wr_cnt, 1);
        chk("t6_wr_addr", {29'd0, wr_addr}, 32'd6);
        chk("t6_wr_cyc", wr_cyc, k0 + 1);
        chk("t6_first_valid", first_ov_cyc, k0 + 8);
        chk("t6_bytes", hs_cnt, 2);
        chk("t6_done_cyc", done_cyc, k0 + 12);
        chk("t6_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
